// File: rtl/srcnn_ctrl_pkg.sv
// Shared types and constants for the SRCNN frame controller.
// Provides the controller state enum, frame counter width and a counter-width helper.
package srcnn_ctrl_pkg;

    localparam int FrameCountWidth = 16;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        FLUSH,
        ABORTED
    } ctrl_state_e;

    // Width needed to hold 0..limit-1, never less than one bit.
    function automatic int count_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/srcnn_frame_controller_beat_counter.sv
// Wrapping beat counter: counts enabled cycles 0..Limit-1 and flags the last value.
// Ports: clock_i, reset_ni, enable, clear (wins over enable), count_o, terminal_o.
module beat_counter
    import srcnn_ctrl_pkg::*;
#(
    parameter int Limit      = 16,
    parameter int CountWidth = count_width(Limit)
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  enable,
    input  logic                  clear,
    output logic [CountWidth-1:0] count_o,
    output logic                  terminal_o
);

    localparam logic [CountWidth-1:0] Last = CountWidth'(Limit - 1);

    assign terminal_o = (count_o == Last);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_o <= '0;
        end else if (clear) begin
            count_o <= '0;
        end else if (enable) begin
            count_o <= terminal_o ? '0 : count_o + CountWidth'(1);
        end
    end

endmodule

// File: rtl/srcnn_frame_controller.sv
// Frame sequencer for the SRCNN engine: admits Height*Width pixels per frame for a commanded
// number of frames, marks the last output pixel of each frame, and aborts by holding the
// engine in reset.
// Ports: start_i/frames_i/abort_i command; busy_o/done_o/aborted_o/frame_index_o status;
// slave_* upstream, core_in_*/core_out_*/core_reset_o engine side, master_* downstream.
// Optional macro SRCNN_PERF_COUNTER_EN adds stall_cycles_o and active_cycles_o.
module srcnn_frame_controller
    import srcnn_ctrl_pkg::*;
#(
    parameter int Height      = 600,
    parameter int Width       = 800,
    parameter int DataWidth   = 24,
    parameter int ResetCycles = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    input  logic [FrameCountWidth-1:0] frames_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic [FrameCountWidth-1:0] frame_index_o,
    input  logic                       slave_valid_i,
    output logic                       slave_ready_o,
    input  logic [DataWidth-1:0]       slave_data_i,
    output logic                       core_in_valid_o,
    input  logic                       core_in_ready_i,
    output logic [DataWidth-1:0]       core_in_data_o,
    input  logic                       core_out_valid_i,
    output logic                       core_out_ready_o,
    input  logic [DataWidth-1:0]       core_out_data_i,
    output logic                       core_reset_o,
    output logic                       master_valid_o,
    input  logic                       master_ready_i,
    output logic [DataWidth-1:0]       master_data_o,
    output logic                       master_last_o
`ifdef SRCNN_PERF_COUNTER_EN
    ,
    output logic [31:0]                stall_cycles_o,
    output logic [31:0]                active_cycles_o
`endif
);

    localparam int Pixels   = Height * Width;
    localparam int PixWidth = count_width(Pixels);
    localparam int FlWidth  = count_width(ResetCycles);

    ctrl_state_e state, state_d;

    logic [FrameCountWidth-1:0] frames_q;
    logic [FrameCountWidth-1:0] in_frame;
    logic [FrameCountWidth-1:0] out_frame;
    logic [PixWidth-1:0]        in_pix;
    logic [PixWidth-1:0]        out_pix;
    logic [FlWidth-1:0]         flush_cnt;

    logic running, out_open, flushing;
    logic in_hs, out_hs;
    logic in_term, out_term, flush_term;
    logic in_final, out_final;
    logic start_ok;
    logic core_reset_q;
    logic unused_counts;

    assign running  = (state == RUN);
    assign out_open = (state == RUN) || (state == DRAIN);
    assign flushing = (state == FLUSH);

    assign core_in_valid_o = slave_valid_i & running;
    assign slave_ready_o   = core_in_ready_i & running;
    assign core_in_data_o  = slave_data_i;

    // Engine output is discarded while it is flushed, otherwise it follows the sink.
    assign master_valid_o   = core_out_valid_i & out_open;
    assign master_data_o    = core_out_data_i;
    assign core_out_ready_o = out_open ? master_ready_i
                                       : (flushing || (state == ABORTED));

    assign in_hs  = core_in_valid_o & core_in_ready_i;
    assign out_hs = master_valid_o & master_ready_i;

    assign start_ok = (state == IDLE) && start_i && (frames_i != '0);

    assign in_final  = in_hs && in_term
                       && (in_frame == frames_q - FrameCountWidth'(1));
    assign out_final = out_hs && out_term
                       && (out_frame == frames_q - FrameCountWidth'(1));

    assign master_last_o = master_valid_o & out_term;
    assign frame_index_o = out_frame;
    assign core_reset_o  = core_reset_q;

    assign unused_counts = ^{in_pix, out_pix, flush_cnt};

    beat_counter #(.Limit(Pixels)) u_in_pix (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .enable    (in_hs),
        .clear     (start_ok),
        .count_o   (in_pix),
        .terminal_o(in_term)
    );

    beat_counter #(.Limit(Pixels)) u_out_pix (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .enable    (out_hs),
        .clear     (start_ok),
        .count_o   (out_pix),
        .terminal_o(out_term)
    );

    // Starts from zero on every FLUSH entry, so the pulse is exactly ResetCycles long.
    beat_counter #(.Limit(ResetCycles)) u_flush (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .enable    (flushing),
        .clear     (!flushing),
        .count_o   (flush_cnt),
        .terminal_o(flush_term)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start_ok) state_d = RUN;
            // Abort outranks any handshake-driven move.
            RUN: begin
                if (abort_i)        state_d = FLUSH;
                else if (out_final) state_d = DONE;
                else if (in_final)  state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_i)        state_d = FLUSH;
                else if (out_final) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            FLUSH:   if (flush_term) state_d = ABORTED;
            ABORTED: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track the state exactly.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            aborted_o    <= 1'b0;
            core_reset_q <= 1'b1;
            frames_q     <= '0;
            in_frame     <= '0;
            out_frame    <= '0;
        end else begin
            state        <= state_d;
            busy_o       <= (state_d == RUN) || (state_d == DRAIN)
                            || (state_d == FLUSH);
            done_o       <= (state_d == DONE);
            aborted_o    <= (state_d == ABORTED);
            core_reset_q <= (state_d == FLUSH);
            if (start_ok) begin
                frames_q  <= frames_i;
                in_frame  <= '0;
                out_frame <= '0;
            end else begin
                if (in_hs && in_term) begin
                    in_frame <= in_frame + FrameCountWidth'(1);
                end
                if (out_hs && out_term) begin
                    out_frame <= out_frame + FrameCountWidth'(1);
                end
            end
        end
    end

`ifdef SRCNN_PERF_COUNTER_EN
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            active_cycles_o <= '0;
            stall_cycles_o  <= '0;
        end else if (start_ok) begin
            active_cycles_o <= '0;
            stall_cycles_o  <= '0;
        end else begin
            if (busy_o && (active_cycles_o != '1)) begin
                active_cycles_o <= active_cycles_o + 32'd1;
            end
            if (master_valid_o && !master_ready_i
                && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_srcnn_frame_controller.sv
// Self-checking bench for srcnn_frame_controller (4x4 frames, fixed-latency engine FIFO).
// A count-based reference model predicts every gate, status and data output each cycle.
module tb_srcnn_frame_controller;

    localparam int H   = 4;
    localparam int W   = 4;
    localparam int DW  = 24;
    localparam int RC  = 4;
    localparam int PIX = H * W;
    localparam int LAT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ACT   = 1;
    localparam int M_DONE  = 2;
    localparam int M_FLUSH = 3;
    localparam int M_ABT   = 4;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          start_i;
    logic [15:0]   frames_i;
    logic          abort_i;
    logic          busy_o, done_o, aborted_o;
    logic [15:0]   frame_index_o;
    logic          slave_valid_i, slave_ready_o;
    logic [DW-1:0] slave_data_i;
    logic          core_in_valid_o, core_in_ready_i;
    logic [DW-1:0] core_in_data_o;
    logic          core_out_valid_i, core_out_ready_o;
    logic [DW-1:0] core_out_data_i;
    logic          core_reset_o;
    logic          master_valid_o, master_ready_i;
    logic [DW-1:0] master_data_o;
    logic          master_last_o;

    always #5 clk = ~clk;

    srcnn_frame_controller #(
        .Height(H), .Width(W), .DataWidth(DW), .ResetCycles(RC)
    ) dut (
        .clock_i         (clk),
        .reset_ni        (reset_ni),
        .start_i         (start_i),
        .frames_i        (frames_i),
        .abort_i         (abort_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .aborted_o       (aborted_o),
        .frame_index_o   (frame_index_o),
        .slave_valid_i   (slave_valid_i),
        .slave_ready_o   (slave_ready_o),
        .slave_data_i    (slave_data_i),
        .core_in_valid_o (core_in_valid_o),
        .core_in_ready_i (core_in_ready_i),
        .core_in_data_o  (core_in_data_o),
        .core_out_valid_i(core_out_valid_i),
        .core_out_ready_o(core_out_ready_o),
        .core_out_data_i (core_out_data_i),
        .core_reset_o    (core_reset_o),
        .master_valid_o  (master_valid_o),
        .master_ready_i  (master_ready_i),
        .master_data_o   (master_data_o),
        .master_last_o   (master_last_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // environment
    logic [DW-1:0] eng_d[$];
    int            eng_t[$];
    int            cyc = 0;
    int            src_left = 0;
    logic [DW-1:0] src_word = '0;
    int            rdy_pct = 100;
    int            cin_pct = 100;
    logic          start_r = 1'b0;
    logic          abort_r = 1'b0;
    logic [15:0]   frames_r = '0;

    // reference model
    int            mph = M_IDLE;
    int            total = 0;
    int            in_cnt = 0;
    int            out_cnt = 0;
    int            fl_left = 0;
    logic [DW-1:0] ref_q[$];

    // per-job statistics
    int dut_in, out_beats, last_cnt, done_cnt, abt_cnt, rst_cyc;

    task automatic clear_stats();
        dut_in = 0; out_beats = 0; last_cnt = 0;
        done_cnt = 0; abt_cnt = 0; rst_cyc = 0;
    endtask

    task automatic step();
        logic act, fl, abt, e_in, e_mv, e_in_hs, e_out_hs;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        slave_valid_i    = (src_left > 0);
        slave_data_i     = src_word;
        master_ready_i   = ($urandom_range(99) < rdy_pct);
        core_in_ready_i  = ($urandom_range(99) < cin_pct);
        core_out_valid_i = (eng_d.size() > 0) && (eng_t[0] <= cyc);
        core_out_data_i  = (eng_d.size() > 0) ? eng_d[0] : '0;
        start_i  = start_r;
        frames_i = frames_r;
        abort_i  = abort_r;
        #2;
        act  = (mph == M_ACT);
        fl   = (mph == M_FLUSH);
        abt  = (mph == M_ABT);
        e_in = act && (in_cnt < total);
        e_mv = act && core_out_valid_i;
        chk("busy", busy_o, act | fl);
        chk("done", done_o, mph == M_DONE);
        chk("aborted", aborted_o, abt);
        chk("core_reset", core_reset_o, fl);
        chk("slave_ready", slave_ready_o, e_in & core_in_ready_i);
        chk("core_in_valid", core_in_valid_o, e_in & slave_valid_i);
        if (core_in_valid_o) chk("core_in_data", core_in_data_o, slave_data_i);
        chk("master_valid", master_valid_o, e_mv);
        chk("core_out_ready", core_out_ready_o,
            act ? master_ready_i : (fl | abt));
        if (e_mv) begin
            chk("master_last", master_last_o, (out_cnt % PIX) == PIX - 1);
            chk("frame_index", frame_index_o, out_cnt / PIX);
        end else begin
            chk("master_last_idle", master_last_o, 0);
        end
        // engine FIFO, synchronously reset by core_reset_o
        if (core_reset_o) begin
            eng_d.delete();
            eng_t.delete();
            rst_cyc++;
        end else begin
            if (core_out_valid_i && core_out_ready_o) begin
                void'(eng_d.pop_front());
                void'(eng_t.pop_front());
            end
            if (core_in_valid_o && core_in_ready_i) begin
                eng_d.push_back(core_in_data_o);
                eng_t.push_back(cyc + LAT);
            end
        end
        if (slave_valid_i && slave_ready_o) begin
            src_left--;
            src_word = DW'($urandom);
            dut_in++;
        end
        done_cnt += int'(done_o);
        abt_cnt  += int'(aborted_o);
        // model bookkeeping
        e_in_hs  = e_in & core_in_ready_i & slave_valid_i;
        e_out_hs = e_mv & master_ready_i;
        if (e_in_hs) begin
            ref_q.push_back(slave_data_i);
            in_cnt++;
        end
        if (e_out_hs) begin
            exp_d = (ref_q.size() > 0) ? ref_q.pop_front() : 'x;
            chk("master_data", master_data_o, exp_d);
            out_cnt++;
            out_beats++;
            last_cnt += int'(master_last_o);
        end
        case (mph)
            M_IDLE: if (start_i && frames_i != 0) begin
                mph = M_ACT;
                total = int'(frames_i) * PIX;
                in_cnt = 0;
                out_cnt = 0;
                ref_q.delete();
            end
            M_ACT: if (abort_i) begin
                mph = M_FLUSH;
                fl_left = RC;
                ref_q.delete();
            end else if (out_cnt == total) begin
                mph = M_DONE;
            end
            M_DONE: mph = M_IDLE;
            M_FLUSH: begin
                fl_left--;
                if (fl_left == 0) mph = M_ABT;
            end
            default: mph = M_IDLE;
        endcase
        start_r = 1'b0;
        abort_r = 1'b0;
        cyc++;
    endtask

    task automatic begin_job(input int f, input int src);
        clear_stats();
        src_left = src;
        frames_r = 16'(f);
        start_r  = 1'b1;
    endtask

    task automatic run_idle(input int budget, input int abort_after);
        for (int i = 0; i < budget; i++) begin
            if (i == abort_after) abort_r = 1'b1;
            step();
            if (mph == M_IDLE) return;
        end
        chk("timeout", mph, M_IDLE);
    endtask

    task automatic run_until_in(input int n);
        for (int i = 0; i < 200; i++) begin
            if (dut_in >= n) return;
            step();
        end
        chk("timeout_in", dut_in, n);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_done"}, done_o, 0);
        chk({pfx, "_aborted"}, aborted_o, 0);
        chk({pfx, "_fidx"}, frame_index_o, 0);
        chk({pfx, "_cin_valid"}, core_in_valid_o, 0);
        chk({pfx, "_slave_ready"}, slave_ready_o, 0);
        chk({pfx, "_master_valid"}, master_valid_o, 0);
        chk({pfx, "_master_last"}, master_last_o, 0);
        chk({pfx, "_cout_ready"}, core_out_ready_o, 0);
        chk({pfx, "_core_reset"}, core_reset_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_ni = 1'b0;
        start_i = 1'b0; frames_i = '0; abort_i = 1'b0;
        slave_valid_i = 1'b1; slave_data_i = '0;
        core_in_ready_i = 1'b1; core_out_valid_i = 1'b1;
        core_out_data_i = '0; master_ready_i = 1'b1;
        clear_stats();
        repeat (2) @(negedge clk);
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        reset_ni = 1'b1;
        step();

        // 1: single frame, free-flowing
        begin_job(1, 100);
        run_idle(200, -1);
        chk("t1_in", dut_in, 16);
        chk("t1_out", out_beats, 16);
        chk("t1_last", last_cnt, 1);
        chk("t1_done", done_cnt, 1);
        step();

        // 2: three frames, random sink stalls
        rdy_pct = 55; cin_pct = 80;
        begin_job(3, 48);
        run_idle(2000, -1);
        chk("t2_out", out_beats, 48);
        chk("t2_last", last_cnt, 3);
        chk("t2_done", done_cnt, 1);
        rdy_pct = 100; cin_pct = 100;

        // 3: source offers more than one frame
        begin_job(1, 20);
        run_idle(200, -1);
        chk("t3_in", dut_in, 16);
        chk("t3_left", src_left, 4);

        // 4: abort after five input beats, then a clean job
        begin_job(2, 100);
        run_until_in(5);
        abort_r = 1'b1;
        run_idle(100, -1);
        chk("t4_rst_cycles", rst_cyc, RC);
        chk("t4_aborted", abt_cnt, 1);
        chk("t4_done", done_cnt, 0);
        begin_job(1, 16);
        run_idle(200, -1);
        chk("t4b_out", out_beats, 16);
        chk("t4b_done", done_cnt, 1);

        // 5: ignored starts and start with abort in IDLE
        begin_job(0, 16);
        repeat (3) step();
        chk("t5_zero_busy", busy_o, 0);
        chk("t5_zero_in", dut_in, 0);
        rdy_pct = 70;
        begin_job(2, 40);
        run_until_in(3);
        frames_r = 16'd5;
        start_r = 1'b1;
        run_idle(1000, -1);
        chk("t5_run_start_out", out_beats, 32);
        chk("t5_run_start_done", done_cnt, 1);
        rdy_pct = 100;
        begin_job(1, 16);
        abort_r = 1'b1;
        run_idle(200, -1);
        chk("t5_sa_done", done_cnt, 1);
        chk("t5_sa_aborted", abt_cnt, 0);

        // 6: reset mid-frame
        begin_job(2, 32);
        run_until_in(7);
        @(negedge clk);
        #1 reset_ni = 1'b0;
        #1 check_reset_vals("t6");
        eng_d.delete(); eng_t.delete(); ref_q.delete();
        mph = M_IDLE;
        @(negedge clk);
        reset_ni = 1'b1;
        begin_job(1, 16);
        run_idle(200, -1);
        chk("t6_out", out_beats, 16);
        chk("t6_last", last_cnt, 1);
        chk("t6_done", done_cnt, 1);

        // random jobs with occasional abort
        for (int j = 0; j < 6; j++) begin
            int f, ab;
            f = $urandom_range(1, 3);
            rdy_pct = $urandom_range(30, 100);
            cin_pct = $urandom_range(50, 100);
            ab = ($urandom_range(1) == 1) ? int'($urandom_range(2, 60)) : -1;
            begin_job(f, f * PIX + 3);
            run_idle(3000, ab);
            chk("rnd_end", done_cnt + abt_cnt, 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
